input_memory_node: RTL

- Streaming load unit on the CGRA north edge; one instance per column.
- Reads a strided vector from the system memory bus using an OBI-style req/gnt/rvalid protocol.
- Buffers the response words and presents them as a valid/ready elastic stream to the top-row PE's north data input.
- Fully decoupled from the PE configuration chain: it never drives the stream while the column is in configuration (conf_en_i high).

---
 rtl/imn_pkg.sv | 20 ++
 rtl/imn_fifo.sv | 64 ++++++
 rtl/input_memory_node.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/imn_pkg.sv
// imn_pkg: shared types and constants for the input memory node.
//   imn_state_e : load FSM states
//   ADDR_WIDTH  : system bus address width
//   imn_cnt_w() : bit width of a counter that must reach 'depth' inclusive
package imn_pkg;

  localparam int ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    IMN_IDLE,
    IMN_ISSUE,
    IMN_DRAIN,
    IMN_DONE
  } imn_state_e;

  function automatic int imn_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/imn_fifo.sv
// imn_fifo: registered synchronous FIFO (no fall-through).
//   clk_i, rst_ni   : clock, async active-low reset
//   flush_i         : synchronous empty, wins over push/pop
//   push_i, din_i   : write side (push on full only legal with a pop)
//   pop_i, dout_o   : read side, dout_o is the current head
//   full_o, empty_o : status
//   count_o         : entries held, 0..DEPTH
module imn_fifo
  import imn_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 4,
  localparam int CW         = imn_cnt_w(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [CW-1:0]         count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
  logic [AW-1:0]                    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]                    count_q;
  logic                             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // a pop frees the slot in the same cycle, so push-on-full is fine with it
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // DEPTH is a power of two, so the pointers wrap naturally
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/input_memory_node.sv
// input_memory_node: strided vector load from the memory bus (OBI-style
// req/gnt/rvalid) into an elastic valid/ready stream for the top-row PE.
//   clk_i, rst_ni, clr_i    : clock, async active-low reset, sync abort
//   conf_en_i               : column in configuration; blocks start, hides stream
//   start_i, base_addr_i,
//   size_i, stride_i        : transfer command (words, byte stride)
//   busy_o, done_o          : status, done_o is a one-cycle pulse
//   req_o, addr_o, gnt_i,
//   rvalid_i, rdata_i       : memory bus
//   dout_o, dout_v_o, dout_r_i : output stream
// Optional: define IMN_PERF_CNT_EN to add stall_cycles_o and
// bus_wait_cycles_o (saturating, cleared on start and clr_i).
module input_memory_node
  import imn_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int SIZE_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr_i,
  input  logic                  conf_en_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [SIZE_WIDTH-1:0] size_i,
  input  logic [SIZE_WIDTH-1:0] stride_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  req_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  input  logic                  gnt_i,
  input  logic                  rvalid_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  dout_v_o,
`ifdef IMN_PERF_CNT_EN
  output logic [31:0]           stall_cycles_o,
  output logic [31:0]           bus_wait_cycles_o,
`endif
  input  logic                  dout_r_i
);

  localparam int            CW      = imn_cnt_w(FIFO_DEPTH);
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(FIFO_DEPTH);

  imn_state_e            state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [SIZE_WIDTH-1:0] size_q, stride_q, issued_q;
  logic [CW-1:0]         outst_q, discard_q, fifo_cnt;
  logic [CW:0]           credit_used;
  logic                  fifo_empty, unused_fifo_full;
  logic                  fifo_push, fifo_pop, grant, rsp_keep, start_ok;

  // Credits: buffered + in-flight words never exceed the FIFO, so a response
  // (which cannot be stalled) always finds room. The sum can only shrink
  // while a request waits for its grant, so req_o stays stable.
  assign credit_used = {1'b0, fifo_cnt} + {1'b0, outst_q};
  assign req_o       = (state_q == IMN_ISSUE) && (credit_used < DEPTH_C);
  assign addr_o      = addr_q;
  assign grant       = req_o && gnt_i;

  // responses owed to an aborted transfer are swallowed
  assign rsp_keep  = rvalid_i && (discard_q == '0);
  assign fifo_push = rsp_keep && !clr_i;
  assign dout_v_o  = !fifo_empty && !conf_en_i;
  assign fifo_pop  = dout_v_o && dout_r_i;

  assign busy_o   = (state_q != IMN_IDLE) || (discard_q != '0);
  assign done_o   = (state_q == IMN_DONE);
  assign start_ok = (state_q == IMN_IDLE) && start_i && !conf_en_i && (discard_q == '0);

  imn_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .flush_i(clr_i),
    .push_i (fifo_push),
    .din_i  (rdata_i),
    .pop_i  (fifo_pop),
    .dout_o (dout_o),
    .full_o (unused_fifo_full),  // credits already guarantee space
    .empty_o(fifo_empty),
    .count_o(fifo_cnt)
  );

  // in-flight tracking; outstanding and discard are never both non-zero
  // because a new start waits for discard to drain
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outst_q   <= '0;
      discard_q <= '0;
    end else if (clr_i) begin
      // everything the bus still owes is dropped: the current backlog plus a
      // grant taken now, minus a response that lands (and is dropped) now
      outst_q   <= '0;
      discard_q <= outst_q + discard_q + CW'(grant) - CW'(rvalid_i);
    end else begin
      outst_q <= outst_q + CW'(grant) - CW'(rsp_keep);
      if (rvalid_i && (discard_q != '0)) discard_q <= discard_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IMN_IDLE;
      addr_q   <= '0;
      size_q   <= '0;
      stride_q <= '0;
      issued_q <= '0;
    end else if (clr_i) begin
      state_q  <= IMN_IDLE;
      issued_q <= '0;
    end else begin
      case (state_q)
        IMN_IDLE: begin
          if (start_ok) begin
            addr_q   <= base_addr_i;
            size_q   <= size_i;
            stride_q <= stride_i;
            issued_q <= '0;
            state_q  <= (size_i == '0) ? IMN_DONE : IMN_ISSUE;
          end
        end
        IMN_ISSUE: begin
          if (grant) begin
            addr_q   <= addr_q + ADDR_WIDTH'(stride_q);
            issued_q <= issued_q + SIZE_WIDTH'(1);
            if (issued_q + SIZE_WIDTH'(1) == size_q) state_q <= IMN_DRAIN;
          end
        end
        IMN_DRAIN: begin
          if ((outst_q == '0) && fifo_empty) state_q <= IMN_DONE;
        end
        IMN_DONE: state_q <= IMN_IDLE;
        default:  state_q <= IMN_IDLE;
      endcase
    end
  end

`ifdef IMN_PERF_CNT_EN
  logic [31:0] stall_q, wait_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q <= '0;
      wait_q  <= '0;
    end else if (clr_i || start_ok) begin
      stall_q <= '0;
      wait_q  <= '0;
    end else begin
      if (dout_v_o && !dout_r_i && (stall_q != '1)) stall_q <= stall_q + 32'd1;
      if (req_o && !gnt_i && (wait_q != '1))         wait_q  <= wait_q + 32'd1;
    end
  end

  assign stall_cycles_o    = stall_q;
  assign bus_wait_cycles_o = wait_q;
`endif

endmodule
